feature_frame_assembler: RTL

FEATURE_FRAME_ASSEMBLER -- requirements
Module: feature_frame_assembler

---
 rtl/feature_frame_assembler_if.sv | 24 ++
 rtl/feature_frame_assembler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/feature_frame_assembler_if.sv
// Acquisition/frame bus of feature_frame_assembler: ADC mux/conversion handshake plus
// the frame valid/ready output. master = assembler side, slave = environment side.
interface feature_frame_assembler_if;
    logic        start;
    logic [2:0]  adc_sel;
    logic        adc_soc;
    logic        adc_eoc;
    logic [7:0]  adc_data;
    logic [23:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;
    logic        err;

    modport master (
        input  start, adc_eoc, adc_data, frame_ready,
        output adc_sel, adc_soc, frame, frame_valid, busy, err
    );

    modport slave (
        output start, adc_eoc, adc_data, frame_ready,
        input  adc_sel, adc_soc, frame, frame_valid, busy, err
    );
endinterface

// File: rtl/feature_frame_assembler.sv
// Sequences a 6-channel ADC acquisition into a packed 24-bit frame with valid/ready output.
// Define FEATURE_FRAME_ASSEMBLER_ROUND_EN for saturating round-to-nearest quantization.
module feature_frame_assembler #(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 63
) (
    input logic                      clk,
    input logic                      rst_n,
    feature_frame_assembler_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StSettle, StSoc, StWaitEoc, StNext, StPublish
    } state_e;

    localparam logic [3:0] SettleLoad  = 4'(SETTLE_CYC);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  ch_q, ch_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] frame_q, frame_d;
    logic        frame_valid_q, frame_valid_d;
    logic        err_q, err_d;
    logic        publish;
    logic [3:0]  sample;

`ifdef FEATURE_FRAME_ASSEMBLER_ROUND_EN
    logic [8:0] rounded;
    assign rounded = {1'b0, bus.adc_data} + 9'd8;
    assign sample  = rounded[8] ? 4'hF : rounded[7:4];
`else
    logic [3:0] unused_adc_lsb;
    assign unused_adc_lsb = bus.adc_data[3:0];
    assign sample         = bus.adc_data[7:4];
`endif

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        settle_d      = settle_q;
        tmo_d         = tmo_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        err_d         = err_q;
        publish       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StSettle;
                    ch_d     = 3'd0;
                    settle_d = SettleLoad;
                end
            end
            StSettle: begin
                // Leaves on the cycle the count would hit zero, so SETTLE_CYC=0 still spends one.
                if (settle_q <= 4'd1) begin
                    state_d = StSoc;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StSoc: begin
                state_d = StWaitEoc;
                tmo_d   = 8'd0;
            end
            StWaitEoc: begin
                if (bus.adc_eoc) begin
                    shadow_d[{ch_q, 2'b00} +: 4] = sample;
                    state_d = StNext;
                end else if (tmo_q == TimeoutLast) begin
                    shadow_d[{ch_q, 2'b00} +: 4] = 4'h0;
                    err_d   = 1'b1;
                    state_d = StNext;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StNext: begin
                if (ch_q == 3'd5) begin
                    state_d = StPublish;
                end else begin
                    ch_d     = ch_q + 3'd1;
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StPublish: begin
                if (!frame_valid_q || bus.frame_ready) begin
                    publish = 1'b1;
                    frame_d = shadow_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A publish in the same cycle as a consume keeps the frame valid.
        if (publish) begin
            frame_valid_d = 1'b1;
        end else if (frame_valid_q && bus.frame_ready) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ch_q          <= 3'd0;
            settle_q      <= 4'd0;
            tmo_q         <= 8'd0;
            shadow_q      <= 24'd0;
            frame_q       <= 24'd0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            settle_q      <= settle_d;
            tmo_q         <= tmo_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.adc_sel     = ch_q;
    assign bus.adc_soc     = (state_q == StSoc);
    assign bus.busy        = (state_q != StIdle);
    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;

endmodule
